// File: rtl/bal_seq.sv
// Power/balance sequencer: gates pwr_up to the balance controller and drives the alarm outputs.
// Optional vld watchdog enabled by defining BAL_SEQ_WDOG_EN.
module bal_seq #(
    parameter bit          fast_sim    = 1'b1,
    parameter int unsigned SETTLE_SMPL = 64,
    parameter logic [15:0] PTCH_LIM    = 16'h0200,
    parameter int unsigned TF_SMPL     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_cmd,
    input  logic        vld,
    input  logic [15:0] ptch,
    input  logic        rider_off,
    input  logic        too_fast,
    input  logic        batt_low,
    output logic        pwr_up,
    output logic        alarm_too_fast,
    output logic        alarm_batt,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        SETTLE = 3'd1,
        RUN    = 3'd2,
        SHUTDN = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_TOP = 8'(SETTLE_SMPL);
    localparam logic [3:0] TF_TOP     = 4'(TF_SMPL);

    state_t      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [7:0]  settle_inc;
    logic [3:0]  tf_q, tf_d;
    logic [15:0] ptch_abs;
    logic        in_lim;
    logic        wd_timeout;

    function automatic logic bal_active(input state_t s);
        return (s == RUN) || (s == SHUTDN);
    endfunction

    assign state = state_q;

    // -32768 has no positive counterpart in 16 bits, so it saturates to 32767
    always_comb begin
        ptch_abs = ptch;
        if (ptch[15])
            ptch_abs = (ptch == 16'h8000) ? 16'h7FFF : (~ptch + 16'd1);
    end

    assign in_lim     = (ptch_abs < PTCH_LIM);
    assign settle_inc = settle_q + 8'd1;

`ifdef BAL_SEQ_WDOG_EN
    localparam logic [19:0] WD_TOP = fast_sim ? 20'd1023 : 20'hFFFFF;

    logic        wd_live;
    logic [19:0] wd_q, wd_d;

    assign wd_live    = (state_q == SETTLE) || bal_active(state_q);
    assign wd_timeout = wd_live && !vld && (wd_q == WD_TOP);

    // Restarts on every vld and whenever a supervised state is (re)entered from OFF/FAULT
    always_comb begin
        wd_d = '0;
        if (wd_live && ((state_d == SETTLE) || bal_active(state_d)) && !vld)
            wd_d = wd_q + 20'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            fault <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            fault <= (state_d == FAULT);
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF: begin
                if (pwr_cmd)
                    state_d = SETTLE;
            end
            SETTLE: begin
                if (wd_timeout)
                    state_d = FAULT;
                else if (!pwr_cmd)
                    state_d = OFF;
                else if (vld && in_lim && (settle_inc == SETTLE_TOP))
                    state_d = RUN;
            end
            RUN: begin
                if (wd_timeout)
                    state_d = FAULT;
                else if (!pwr_cmd)
                    state_d = rider_off ? OFF : SHUTDN;
                else if (batt_low && rider_off)
                    state_d = OFF;
            end
            SHUTDN: begin
                if (wd_timeout)
                    state_d = FAULT;
                else if (rider_off)
                    state_d = OFF;
                else if (pwr_cmd)
                    state_d = RUN;
            end
            FAULT: begin
                if (!pwr_cmd)
                    state_d = OFF;
            end
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        settle_d = '0;
        if ((state_q == SETTLE) && (state_d == SETTLE)) begin
            settle_d = settle_q;
            if (vld)
                settle_d = in_lim ? settle_inc : '0;
        end
    end

    always_comb begin
        tf_d = '0;
        if (bal_active(state_q) && bal_active(state_d)) begin
            tf_d = tf_q;
            if (vld)
                tf_d = !too_fast ? '0 : ((tf_q == TF_TOP) ? tf_q : tf_q + 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= OFF;
            settle_q       <= '0;
            tf_q           <= '0;
            pwr_up         <= 1'b0;
            alarm_too_fast <= 1'b0;
            alarm_batt     <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            tf_q           <= tf_d;
            pwr_up         <= bal_active(state_d);
            alarm_too_fast <= bal_active(state_d) && (tf_d == TF_TOP);
            alarm_batt     <= batt_low && bal_active(state_d);
        end
    end

endmodule

// File: tb/tb_bal_seq.sv
// Directed bench for bal_seq with SETTLE_SMPL=4, TF_SMPL=4, fast_sim=1.
module tb_bal_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwr_cmd, vld, rider_off, too_fast, batt_low;
    logic [15:0] ptch;
    logic        pwr_up, alarm_too_fast, alarm_batt, fault;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    bal_seq #(
        .fast_sim    (1'b1),
        .SETTLE_SMPL (4),
        .PTCH_LIM    (16'h0200),
        .TF_SMPL     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwr_cmd        (pwr_cmd),
        .vld            (vld),
        .ptch           (ptch),
        .rider_off      (rider_off),
        .too_fast       (too_fast),
        .batt_low       (batt_low),
        .pwr_up         (pwr_up),
        .alarm_too_fast (alarm_too_fast),
        .alarm_batt     (alarm_batt),
        .fault          (fault),
        .state          (state)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at 2ms, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vld_pulse(input logic [15:0] p);
        vld  = 1'b1;
        ptch = p;
        tick();
        vld  = 1'b0;
    endtask

    task automatic goto_run();
        pwr_cmd   = 1'b1;
        rider_off = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) vld_pulse(16'h0010);
    endtask

    task automatic goto_off();
        pwr_cmd   = 1'b0;
        rider_off = 1'b1;
        tick();
        rider_off = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwr_cmd = 1'b0; vld = 1'b0; ptch = '0;
        rider_off = 1'b0; too_fast = 1'b0; batt_low = 1'b0;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
        checks++; if ({pwr_up, alarm_too_fast, alarm_batt, fault} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b exp 0000", {pwr_up, alarm_too_fast, alarm_batt, fault}); end
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_off: got %0d exp 0", state); end
    endtask

    task automatic test_power_up();
        pwr_cmd = 1'b1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL pu_settle: got %0d exp 1", state); end
        vld_pulse(16'h0010);
        vld_pulse(16'h0010);
        tick();
        vld_pulse(16'h0010);
        checks++; if (state !== 3'd1 || pwr_up !== 1'b0) begin errors++; $display("FAIL pu_third: got state %0d pwr_up %b exp 1/0", state, pwr_up); end
        vld_pulse(16'h0010);
        checks++; if (state !== 3'd2 || pwr_up !== 1'b1) begin errors++; $display("FAIL pu_run: got state %0d pwr_up %b exp 2/1", state, pwr_up); end
        goto_off();
        checks++; if (state !== 3'd0 || pwr_up !== 1'b0) begin errors++; $display("FAIL pu_off: got state %0d pwr_up %b exp 0/0", state, pwr_up); end
    endtask

    task automatic test_settle_restart();
        pwr_cmd = 1'b1;
        tick();
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'hFD00);
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'h0010);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_6th: got %0d exp 1", state); end
        vld_pulse(16'h0010);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL restart_7th: got %0d exp 2", state); end
        goto_off();
        pwr_cmd = 1'b1;
        tick();
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'h0010);
        vld_pulse(16'h8000);
        vld_pulse(16'h01FF); vld_pulse(16'hFE01);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_8000: got %0d exp 1", state); end
        vld_pulse(16'h0200);
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'h0010);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_lim_edge: got %0d exp 1", state); end
        vld_pulse(16'h0010);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL restart_lim_run: got %0d exp 2", state); end
        goto_off();
        pwr_cmd = 1'b1;
        tick();
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'h0010);
        pwr_cmd = 1'b0;
        vld_pulse(16'h0010);
        checks++; if (state !== 3'd0 || pwr_up !== 1'b0) begin errors++; $display("FAIL settle_cmd_drop: got state %0d pwr_up %b exp 0/0", state, pwr_up); end
    endtask

    task automatic test_rider_hold();
        goto_run();
        pwr_cmd = 1'b0;
        tick();
        checks++; if (state !== 3'd3 || pwr_up !== 1'b1) begin errors++; $display("FAIL hold_shutdn: got state %0d pwr_up %b exp 3/1", state, pwr_up); end
        pwr_cmd = 1'b1;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL hold_resume: got %0d exp 2", state); end
        pwr_cmd = 1'b0;
        tick();
        rider_off = 1'b1;
        tick();
        checks++; if (state !== 3'd0 || pwr_up !== 1'b0) begin errors++; $display("FAIL hold_off: got state %0d pwr_up %b exp 0/0", state, pwr_up); end
        rider_off = 1'b0;
    endtask

    task automatic test_too_fast();
        goto_run();
        too_fast = 1'b1;
        vld_pulse(16'h0010); vld_pulse(16'h0010); vld_pulse(16'h0010);
        checks++; if (alarm_too_fast !== 1'b0) begin errors++; $display("FAIL tf_three: got %b exp 0", alarm_too_fast); end
        vld_pulse(16'h0010);
        checks++; if (alarm_too_fast !== 1'b1) begin errors++; $display("FAIL tf_four: got %b exp 1", alarm_too_fast); end
        vld_pulse(16'h0010);
        tick();
        checks++; if (alarm_too_fast !== 1'b1) begin errors++; $display("FAIL tf_sat_hold: got %b exp 1", alarm_too_fast); end
        too_fast = 1'b0;
        vld_pulse(16'h0010);
        checks++; if (alarm_too_fast !== 1'b0) begin errors++; $display("FAIL tf_clear: got %b exp 0", alarm_too_fast); end
        goto_off();
    endtask

    task automatic test_batt();
        goto_run();
        batt_low = 1'b1;
        tick();
        checks++; if (alarm_batt !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL batt_run: got alarm %b state %0d exp 1/2", alarm_batt, state); end
        rider_off = 1'b1;
        tick();
        checks++; if (alarm_batt !== 1'b0 || state !== 3'd0 || pwr_up !== 1'b0) begin errors++; $display("FAIL batt_off: got alarm %b state %0d pwr_up %b exp 0/0/0", alarm_batt, state, pwr_up); end
        rider_off = 1'b0;
        tick();
        checks++; if (alarm_batt !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL batt_settle: got alarm %b state %0d exp 0/1", alarm_batt, state); end
        batt_low = 1'b0;
        pwr_cmd  = 1'b0;
        tick();
    endtask

`ifdef BAL_SEQ_WDOG_EN
    task automatic test_wdog();
        goto_run();
        for (int i = 0; i < 1023; i++) tick();
        checks++; if (state !== 3'd2 || fault !== 1'b0) begin errors++; $display("FAIL wd_pre: got state %0d fault %b exp 2/0", state, fault); end
        tick();
        checks++; if (state !== 3'd4 || fault !== 1'b1 || pwr_up !== 1'b0) begin errors++; $display("FAIL wd_fault: got state %0d fault %b pwr_up %b exp 4/1/0", state, fault, pwr_up); end
        tick(); tick();
        checks++; if (state !== 3'd4 || fault !== 1'b1) begin errors++; $display("FAIL wd_hold: got state %0d fault %b exp 4/1", state, fault); end
        pwr_cmd = 1'b0;
        tick();
        checks++; if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL wd_exit: got state %0d fault %b exp 0/0", state, fault); end
    endtask
`endif

    task automatic test_async_reset();
        goto_run();
        batt_low = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || {pwr_up, alarm_too_fast, alarm_batt, fault} !== 4'b0000) begin errors++; $display("FAIL async_reset: got state %0d outs %b exp 0/0000", state, {pwr_up, alarm_too_fast, alarm_batt, fault}); end
        batt_low = 1'b0;
        pwr_cmd  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset: got %0d exp 0", state); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_settle_restart();
        test_rider_hold();
        test_too_fast();
        test_batt();
`ifdef BAL_SEQ_WDOG_EN
        test_wdog();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bal_seq.md
Name: bal_seq

Overview:
Power/balance sequencer that gates the balance controller's pwr_up input. It decides when balancing may start, keeps it running while a rider is aboard, and shuts it down safely. It sits between the rider-authorization and sensor interfaces on one side and the balance controller on the other. Alarm outputs feed the piezo driver.

Parameters:
fast_sim, 1, shrinks the watchdog timeout for simulation
SETTLE_SMPL, 64, consecutive in-limit pitch samples required before RUN (1..255)
PTCH_LIM, 16'h0200, settle pitch magnitude limit (unsigned compare, strict <)
TF_SMPL, 4, consecutive too_fast samples before the alarm (1..15)

Ports:
clk  in  1  50MHz system clock
rst_n  in  1  asynchronous active-low reset
pwr_cmd  in  1  level request to power balance (from auth block); synchronous
vld  in  1  one-cycle strobe, new ptch sample
ptch  in  16  signed pitch from inertial_intf
rider_off  in  1  no rider detected
too_fast  in  1  from balance controller
batt_low  in  1  battery below threshold; synchronous
pwr_up  out  1  registered; to balance controller
alarm_too_fast  out  1  registered
alarm_batt  out  1  registered
fault  out  1  registered (watchdog only)
state  out  3  current FSM state encoding

Behaviour:
- Reset (asynchronous, any time, mid-operation included): state=OFF. All outputs 0. All counters 0.
- State encodings: OFF=0, SETTLE=1, RUN=2, SHUTDN=3, FAULT=4. Codes 5-7 recover to OFF on the next clock.
- All transitions take effect on the clock edge after the condition is seen. Outputs are registered from the next state, so pwr_up changes on the same edge as state.
- OFF: pwr_up=0. If pwr_cmd=1 -> SETTLE; settle_cnt cleared.
- SETTLE: pwr_up=0.
  - pwr_cmd=0 -> OFF.
  - On vld, compute |ptch| as 16-bit unsigned; -32768 saturates to 32767.
  - If |ptch| < PTCH_LIM, settle_cnt++. Otherwise settle_cnt=0.
  - When settle_cnt reaches SETTLE_SMPL -> RUN.
  - Non-vld cycles hold the count.
- RUN: pwr_up=1.
  - pwr_cmd=0 & rider_off=1 -> OFF.
  - pwr_cmd=0 & rider_off=0 -> SHUTDN.
  - batt_low=1 & rider_off=1 -> OFF.
- SHUTDN: pwr_up=1 (keep balancing the rider).
  - rider_off=1 -> OFF.
  - pwr_cmd=1 -> RUN.
- too_fast filter: 4-bit tf_cnt, active only in RUN/SHUTDN, otherwise held at 0.
  - On vld with too_fast=1, tf_cnt++ saturating at TF_SMPL.
  - On vld with too_fast=0, tf_cnt=0.
  - alarm_too_fast = (tf_cnt==TF_SMPL).
- alarm_batt = batt_low & (next state is RUN or SHUTDN).
- Priority within a cycle: watchdog timeout > pwr_cmd/rider_off exit conditions > batt shutdown > settle completion.
- A vld that completes the settle count in the same cycle as pwr_cmd falling -> OFF.

Optional Feature:
BAL_SEQ_WDOG_EN
- Defined:
  - A vld watchdog counter runs in SETTLE, RUN and SHUTDN. It clears on every vld and on entry to those states.
  - Timeout is 2^20 clk cycles, or 2^10 when fast_sim=1.
  - On timeout -> FAULT: pwr_up=0, fault=1, alarms 0.
  - FAULT exits to OFF only when pwr_cmd=0; fault clears on that edge.
- Undefined: no watchdog logic, FAULT is unreachable, fault is tied to 0.

Test Plan:
- Power-up: SETTLE_SMPL=4, pwr_cmd=1, four vld with ptch=16'h0010 -> state 0→1, then 2 on the edge after the 4th vld; pwr_up=1 that same edge.
- Settle restart: ptch sequence 0010,0010,FD00(-768),0010×4 -> RUN only after the 7th vld. Also ptch=8000 must reset the count.
- Rider hold: in RUN drop pwr_cmd with rider_off=0 -> SHUTDN, pwr_up stays 1. Assert rider_off -> OFF, pwr_up=0 next edge.
- too_fast: TF_SMPL=4, vld×3 with too_fast=1 -> alarm 0; 4th -> alarm 1; vld with too_fast=0 -> alarm 0.
- Battery: in RUN, batt_low=1 -> alarm_batt=1 and still RUN; add rider_off=1 -> OFF, alarm_batt=0.
- Watchdog (BAL_SEQ_WDOG_EN, fast_sim=1): in RUN stop vld for 1024 cycles -> FAULT, fault=1, pwr_up=0. pwr_cmd=1 holds FAULT; pwr_cmd=0 -> OFF. Async reset mid-RUN -> all outputs 0 immediately.
